// File: rtl/fetch_pkg.sv
// Shared fetch definitions: state encoding, instruction geometry and the
// address range check also used by the data-memory path.
package fetch_pkg;

  typedef enum logic {
    RUN,
    FAULT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned INSTR_ALIGN_BITS = 2;

  // True when the word index of pc lies inside a memory of 2**depth_pow words.
  function automatic logic in_range(input logic [63:0] pc, input int unsigned depth_pow);
    return (pc >> INSTR_ALIGN_BITS) < (64'd1 << depth_pow);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory and hands instructions to decode over a valid/ready handshake.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH    = 64,
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter int unsigned            MEM_DEPTH_POW = 10,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic [DATA_WIDTH-1:0] imem_instr_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic                  dec_valid_out,
  input  logic                  dec_ready_in,
  output logic [DATA_WIDTH-1:0] dec_instr_out,
  output logic [ADDR_WIDTH-1:0] dec_pc_out,
  output logic                  fault_out,
  output logic [31:0]           fetch_count_out
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] dpc_q, dpc_d;
  logic [31:0]           count_q, count_d;

  logic pc_legal;
  logic redir_legal;
  logic slot_free;

  always_comb begin
    pc_legal    = (pc_q[INSTR_ALIGN_BITS-1:0] == '0) &&
                  in_range(64'(pc_q), MEM_DEPTH_POW);
    redir_legal = (redirect_pc_in[INSTR_ALIGN_BITS-1:0] == '0) &&
                  in_range(64'(redirect_pc_in), MEM_DEPTH_POW);
    // The decode register can take a new word if empty or being drained now.
    slot_free   = !valid_q || dec_ready_in;

    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    count_d = count_q;

    if (redirect_valid_in) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc_in;
      state_d = redir_legal ? RUN : FAULT;
    end else if (state_q == RUN && slot_free) begin
      if (pc_legal) begin
        valid_d = 1'b1;
        instr_d = imem_instr_in;
        dpc_d   = pc_q;
        pc_d    = pc_q + ADDR_WIDTH'(INSTR_BYTES);
        count_d = count_q + 32'd1;
      end else begin
        // Overrun: any held word has just been accepted, so the register empties.
        valid_d = 1'b0;
        state_d = FAULT;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      dpc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      count_q <= count_d;
    end
  end

  assign imem_addr_out   = pc_q;
  assign dec_valid_out   = valid_q;
  assign dec_instr_out   = instr_q;
  assign dec_pc_out      = dpc_q;
  assign fault_out       = (state_q == FAULT);
  assign fetch_count_out = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a queue-based delivery model predicts each
// instruction decode should receive; a negedge monitor compares.
module tb_instr_fetch;

  localparam int unsigned DEPTH_POW = 6;
  localparam logic [63:0] MEM_BYTES = 64'd256;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [63:0] imem_addr_out;
  logic [31:0] imem_instr_in;
  logic        redirect_valid_in;
  logic [63:0] redirect_pc_in;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [31:0] dec_instr_out;
  logic [63:0] dec_pc_out;
  logic        fault_out;
  logic [31:0] fetch_count_out;

  logic [31:0] mem [64];
  logic [5:0]  widx;

  assign widx          = imem_addr_out[7:2];
  assign imem_instr_in = (imem_addr_out < MEM_BYTES) ? mem[widx] : 32'hDEAD_BEEF;

  instr_fetch #(
    .ADDR_WIDTH   (64),
    .DATA_WIDTH   (32),
    .MEM_DEPTH_POW(DEPTH_POW),
    .RESET_PC     (64'h0)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .imem_addr_out    (imem_addr_out),
    .imem_instr_in    (imem_instr_in),
    .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in   (redirect_pc_in),
    .dec_valid_out    (dec_valid_out),
    .dec_ready_in     (dec_ready_in),
    .dec_instr_out    (dec_instr_out),
    .dec_pc_out       (dec_pc_out),
    .fault_out        (fault_out),
    .fetch_count_out  (fetch_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_pc    = 64'h0;
  logic        m_fault = 1'b0;
  logic [31:0] m_count = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic legal(input logic [63:0] a);
    return (a % 4 == 0) && (a < MEM_BYTES);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc    = 64'h0;
    m_fault = 1'b0;
    m_count = 32'h0;
  endtask

  // Effect of one clock edge on the delivery stream. An empty queue means the
  // decode register is free (the monitor pops words as decode takes them).
  task automatic model_edge(input logic rv, input logic [63:0] t);
    if (rv) begin
      exp_q.delete();
      m_pc    = t;
      m_fault = !legal(t);
    end else if (!m_fault && exp_q.size() == 0) begin
      if (legal(m_pc)) begin
        exp_q.push_back('{pc: m_pc, instr: mem[m_pc[7:2]]});
        m_pc    = m_pc + 64'd4;
        m_count = m_count + 32'd1;
      end else begin
        m_fault = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [63:0] t);
    dec_ready_in      = r;
    redirect_valid_in = rv;
    redirect_pc_in    = t;
    @(posedge clk_in);
    #1;
    model_edge(rv, t);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(dec_valid_out), 64'd0);
    chk({tag, "_instr"}, 64'(dec_instr_out), 64'd0);
    chk({tag, "_dpc"},   dec_pc_out, 64'd0);
    chk({tag, "_fault"}, 64'(fault_out), 64'd0);
    chk({tag, "_count"}, 64'(fetch_count_out), 64'd0);
    chk({tag, "_addr"},  imem_addr_out, 64'd0);
  endtask

  // Monitor: compares the DUT against the model away from the active edge.
  always @(negedge clk_in) begin
    chk("mon_valid", 64'(dec_valid_out), 64'(exp_q.size() != 0));
    chk("mon_addr",  imem_addr_out, m_pc);
    chk("mon_fault", 64'(fault_out), 64'(m_fault));
    chk("mon_count", 64'(fetch_count_out), 64'(m_count));
    if (dec_valid_out && dec_ready_in) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_word", 64'(dec_valid_out), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_pc",    dec_pc_out, e.pc);
        chk("mon_instr", 64'(dec_instr_out), 64'(e.instr));
      end
    end
  end

  initial begin
    logic [31:0] saved_count;
    logic [63:0] t;
    logic        did_rst;

    rst_in            = 1'b1;
    dec_ready_in      = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 64'h0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_8193;

    #3;
    chk_reset_vals("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Free run, then stall holding PC 4.
    step(1'b1, 1'b0, 64'h0);
    chk("first_pc",    dec_pc_out, 64'h0);
    chk("first_instr", 64'(dec_instr_out), 64'h0000_0013);
    step(1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 64'h0);
      chk("stall_pc",    dec_pc_out, 64'h4);
      chk("stall_instr", 64'(dec_instr_out), 64'h0010_0093);
      chk("stall_addr",  imem_addr_out, 64'h8);
      chk("stall_count", 64'(fetch_count_out), 64'd2);
    end
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    chk("run_pc",     dec_pc_out, 64'hC);
    chk("run_count4", 64'(fetch_count_out), 64'd4);

    // Redirect during a stall.
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 64'h40);
    chk("redir_flush", 64'(dec_valid_out), 64'd0);
    step(1'b1, 1'b0, 64'h0);
    chk("redir_valid", 64'(dec_valid_out), 64'd1);
    chk("redir_pc",    dec_pc_out, 64'h40);
    chk("redir_instr", 64'(dec_instr_out), 64'(mem[16]));

    // Misaligned redirect, then recovery.
    step(1'b1, 1'b1, 64'h42);
    chk("mis_fault", 64'(fault_out), 64'd1);
    chk("mis_valid", 64'(dec_valid_out), 64'd0);
    saved_count = fetch_count_out;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0);
    chk("mis_count_held", 64'(fetch_count_out), 64'(saved_count));
    step(1'b1, 1'b1, 64'h10);
    chk("recover_fault", 64'(fault_out), 64'd0);
    step(1'b1, 1'b0, 64'h0);
    chk("recover_pc", dec_pc_out, 64'h10);

    // Sequential overrun at the top of memory.
    step(1'b1, 1'b1, 64'hF0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'h0);
    chk("overrun_fault", 64'(fault_out), 64'd1);
    chk("overrun_addr",  imem_addr_out, 64'h100);
    chk("overrun_last",  dec_pc_out, 64'hFC);

    // Randomized traffic with one asynchronous reset mid-stream.
    did_rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i >= 150 && !did_rst && dec_valid_out) begin
        did_rst = 1'b1;
        rst_in  = 1'b1;
        #1;
        chk_reset_vals("midreset");
        model_reset();
        #1;
        rst_in = 1'b0;
      end
      case ($urandom % 5)
        0:       t = 64'($urandom_range(0, 63)) << 2;
        1:       t = (64'($urandom_range(0, 63)) << 2) | 64'($urandom_range(1, 3));
        2:       t = 64'h100 + (64'($urandom_range(0, 15)) << 2);
        3:       t = 64'hF0 + (64'($urandom_range(0, 3)) << 2);
        default: t = 64'hFFFF_FFFF_FFFF_FFFC;
      endcase
      step(($urandom % 4) != 0, ($urandom % 10) == 0, t);
    end
    chk("random_reset_seen", 64'(did_rst), 64'd1);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
